// File: rtl/ff_autoplay_seq.sv
// ff_autoplay_seq
// Attract/auto-play input sequencer for the foodfight core. Debounces the
// three raw board buttons and, while enable is high, plays a timed
// coin -> start -> periodic-throw sequence on the active-low game switches.
// The manual buttons are always OR-merged with the automatic pulses.
//
// Optional feature macro: FF_AUTOPLAY_REPEAT_EN
//   defined   - after PLAY_CYC cycles in PLAY the sequence restarts at WAIT_COIN
//   undefined - PLAY persists until enable drops or reset
module ff_autoplay_seq #(
    parameter int DEBOUNCE_CYC = 3000,
    parameter int COIN_DELAY   = 1200000,
    parameter int PULSE_LEN    = 120000,
    parameter int START_GAP    = 2400000,
    parameter int THROW_PERIOD = 600000,
    parameter int PLAY_CYC     = 48000000
) (
    input  logic       clk12m,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    output logic       sw_coin1_n,
    output logic       sw_start1_n,
    output logic       sw_throw1_n,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_COIN  = 3'd1,
        COIN       = 3'd2,
        WAIT_START = 3'd3,
        START      = 3'd4,
        PLAY       = 3'd5
    } state_t;

    // Timer reload values; each timed state lasts (load + 1) cycles.
    localparam logic [23:0] DB_LAST    = 24'(DEBOUNCE_CYC - 1);
    localparam logic [23:0] COIN_LOAD  = 24'(COIN_DELAY - 1);
    localparam logic [23:0] PULSE_LOAD = 24'(PULSE_LEN - 1);
    localparam logic [23:0] GAP_LOAD   = 24'(START_GAP - 1);
    localparam logic [23:0] THROW_LOAD = 24'(THROW_PERIOD - 1);
    // Throw is asserted while the PLAY timer is at or above this value,
    // which covers the first PULSE_LEN cycles of every throw period.
    localparam logic [23:0] THROW_ON   = 24'(THROW_PERIOD - PULSE_LEN);

    // A configuration outside the legal ranges would make the counters wrap
    // in surprising ways, so such a build simply never leaves IDLE.
    localparam bit CFG_OK = (DEBOUNCE_CYC >= 1) && (COIN_DELAY >= 1) &&
                            (PULSE_LEN >= 1) && (START_GAP >= 1) &&
                            (THROW_PERIOD >= 1) && (PLAY_CYC >= 1) &&
                            (PULSE_LEN < THROW_PERIOD) &&
                            (DEBOUNCE_CYC < (1 << 24)) && (COIN_DELAY < (1 << 24)) &&
                            (PULSE_LEN < (1 << 24)) && (START_GAP < (1 << 24)) &&
                            (THROW_PERIOD < (1 << 24)) && (PLAY_CYC < (1 << 26));

    // Button path: index 0 = coin (button1), 1 = start (button2), 2 = throw (button3).
    logic [2:0]       raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       deb_q;
    logic [2:0]       deb_next;
    logic [2:0][23:0] db_cnt_q;
    logic [2:0][23:0] db_cnt_next;

    // Sequencer state.
    state_t      state_q;
    state_t      state_next;
    logic [23:0] timer_q;
    logic [23:0] timer_next;
    logic        auto_coin;
    logic        auto_start;
    logic        auto_throw;

`ifdef FF_AUTOPLAY_REPEAT_EN
    localparam logic [25:0] PLAY_LOAD = 26'(PLAY_CYC - 1);
    logic [25:0] play_q;
    logic [25:0] play_next;
`endif

    assign raw   = {button3, button2, button1};
    assign state = state_q;

    // Two-flop synchronisers plus debounced levels and their stability counters.
    always_ff @(posedge clk12m) begin
        if (!reset_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            sync_a   <= raw;
            sync_b   <= sync_a;
            deb_q    <= deb_next;
            db_cnt_q <= db_cnt_next;
        end
    end

    // A debounced level flips only once the synchronised input has disagreed
    // with it for DEBOUNCE_CYC consecutive cycles; agreement clears the count.
    always_comb begin
        deb_next    = deb_q;
        db_cnt_next = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync_b[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_next[i] = sync_b[i];
                end else begin
                    db_cnt_next[i] = db_cnt_q[i] + 24'd1;
                end
            end
        end
    end

    // Next-state and timer decode; dropping enable outranks every other exit.
    always_comb begin
        state_next = state_q;
        timer_next = (timer_q == '0) ? '0 : (timer_q - 24'd1);
`ifdef FF_AUTOPLAY_REPEAT_EN
        play_next  = (play_q == '0) ? '0 : (play_q - 26'd1);
`endif
        if ((state_q != IDLE) && !enable) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_next = '0;
                    if (enable && CFG_OK) begin
                        state_next = WAIT_COIN;
                        timer_next = COIN_LOAD;
                    end
                end
                WAIT_COIN: begin
                    if (timer_q == '0) begin
                        state_next = COIN;
                        timer_next = PULSE_LOAD;
                    end
                end
                COIN: begin
                    if (timer_q == '0) begin
                        state_next = WAIT_START;
                        timer_next = GAP_LOAD;
                    end
                end
                WAIT_START: begin
                    if (timer_q == '0) begin
                        state_next = START;
                        timer_next = PULSE_LOAD;
                    end
                end
                START: begin
                    if (timer_q == '0) begin
                        state_next = PLAY;
                        timer_next = THROW_LOAD;
`ifdef FF_AUTOPLAY_REPEAT_EN
                        play_next  = PLAY_LOAD;
`endif
                    end
                end
                PLAY: begin
`ifdef FF_AUTOPLAY_REPEAT_EN
                    if (play_q == '0) begin
                        state_next = WAIT_COIN;
                        timer_next = COIN_LOAD;
                    end else if (timer_q == '0) begin
                        timer_next = THROW_LOAD;
                    end
`else
                    if (timer_q == '0) begin
                        timer_next = THROW_LOAD;
                    end
`endif
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Automatic pulses follow the state being entered so they line up with the
    // registered outputs on the same edge.
    always_comb begin
        auto_coin  = (state_next == COIN);
        auto_start = (state_next == START);
        auto_throw = (state_next == PLAY) && (timer_next >= THROW_ON);
    end

    // FSM registers and the registered, active-low switch outputs.
    always_ff @(posedge clk12m) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            busy        <= 1'b0;
            sw_coin1_n  <= 1'b1;
            sw_start1_n <= 1'b1;
            sw_throw1_n <= 1'b1;
        end else begin
            state_q     <= state_next;
            timer_q     <= timer_next;
            busy        <= (state_next != IDLE);
            sw_coin1_n  <= ~(deb_next[0] | auto_coin);
            sw_start1_n <= ~(deb_next[1] | auto_start);
            sw_throw1_n <= ~(deb_next[2] | auto_throw);
        end
    end

`ifdef FF_AUTOPLAY_REPEAT_EN
    // Length of the current game before the sequence restarts.
    always_ff @(posedge clk12m) begin
        if (!reset_n) begin
            play_q <= '0;
        end else begin
            play_q <= play_next;
        end
    end
`endif

endmodule
